// File: rtl/serial_rx_frame_ctrl_if.sv
// rtl/serial_rx_frame_ctrl_if.sv - received-word valid/ready handshake between receiver and consumer
interface serial_rx_frame_ctrl_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/serial_rx_frame_ctrl.sv
// rtl/serial_rx_frame_ctrl.sv - oversampling serial frame receiver (start, N_BITS LSB-first, stop)
module serial_rx_frame_ctrl #(
  parameter int N_BITS = 8,
  parameter int OVS    = 16,
  parameter int DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  serial_rx_frame_ctrl_if.master stream,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(N_BITS + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic              rx_m, rx_s;
  logic [DW-1:0]     div_cnt;
  logic [SW-1:0]     s_cnt, s_n;
  logic [BW-1:0]     b_cnt, b_n;
  logic [N_BITS-1:0] sreg;
  logic              tick, shift_en, store_en, ferr_en;

  // Divider is parked at 0 in IDLE so every frame's sampling grid starts at its start edge.
  assign tick = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s_cnt;
    b_n      = b_cnt;
    shift_en = 1'b0;
    store_en = 1'b0;
    ferr_en  = 1'b0;
    case (state)
      IDLE: begin
        s_n = '0;
        b_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (tick) begin
        if (s_cnt == SW'(OVS/2 - 1)) begin
          s_n     = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          s_n = s_cnt + SW'(1);
        end
      end
      DATA: if (tick) begin
        if (s_cnt == SW'(OVS - 1)) begin
          shift_en = 1'b1;
          s_n      = '0;
          b_n      = b_cnt + BW'(1);
          if (b_cnt == BW'(N_BITS - 1)) state_n = STOP;
        end else begin
          s_n = s_cnt + SW'(1);
        end
      end
      STOP: if (tick) begin
        if (s_cnt == SW'(OVS - 1)) begin
          s_n      = '0;
          state_n  = IDLE;
          store_en = rx_s;
          ferr_en  = !rx_s;
        end else begin
          s_n = s_cnt + SW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt           <= '0;
      s_cnt             <= '0;
      b_cnt             <= '0;
      sreg              <= '0;
      stream.data_out   <= '0;
      stream.data_valid <= 1'b0;
      frame_err         <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
      s_cnt   <= s_n;
      b_cnt   <= b_n;
      if (shift_en) sreg <= {rx_s, sreg[N_BITS-1:1]};
      // A store in the same cycle as an accept keeps valid high: the new word replaces the taken one.
      if (store_en) begin
        stream.data_out   <= sreg;
        stream.data_valid <= 1'b1;
      end else if (stream.data_valid && stream.data_ready) begin
        stream.data_valid <= 1'b0;
      end
      frame_err <= ferr_en;
      overrun   <= store_en && stream.data_valid && !stream.data_ready;
    end
  end

endmodule

// File: tb/tb_serial_rx_frame_ctrl.sv
// tb/tb_serial_rx_frame_ctrl.sv - scoreboard bench for serial_rx_frame_ctrl
module tb_serial_rx_frame_ctrl;
  localparam int N_BITS  = 8;
  localparam int OVS     = 16;
  localparam int DIV     = 4;
  localparam int BIT_CLK = OVS * DIV;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic busy, frame_err, overrun;

  serial_rx_frame_ctrl_if #(.N_BITS(N_BITS)) stream_if ();

  serial_rx_frame_ctrl #(.N_BITS(N_BITS), .OVS(OVS), .DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .stream    (stream_if),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int words_seen = 0, ferr_seen = 0, ovr_seen = 0, valid_cycles = 0;
  int fall_cyc = 0, rise_cyc = -1;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sample just after the falling edge: values seen here are what the next rising edge acts on.
  always begin
    @(negedge clk);
    #1;
    if (frame_err) ferr_seen++;
    if (overrun) ovr_seen++;
    if (frame_err || overrun) check_eq("err_ovr_exclusive", {31'b0, frame_err & overrun}, 32'd0);
    if (stream_if.data_valid) valid_cycles++;
    if (stream_if.data_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = stream_if.data_valid;
    if (stream_if.data_valid && stream_if.data_ready) begin
      if (exp_q.size() == 0) check_eq("word_expected", exp_q.size(), 32'd1);
      else check_eq("word", {24'b0, stream_if.data_out}, {24'b0, exp_q.pop_front()});
      words_seen++;
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_it);
    if (expect_it) exp_q.push_back(d);
    fall_cyc = cyc;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < N_BITS; i++) hold(d[i], BIT_CLK);
    hold(stop_bit, BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int left;
    left = budget;
    while (exp_q.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    check_eq("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, n, v_before, w_before;
    logic [7:0] c3;
    stream_if.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", {24'b0, stream_if.data_out}, 32'd0);
    check_eq("rst_data_valid", {31'b0, stream_if.data_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check_eq("rst_overrun", {31'b0, overrun}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 10);

    // 1: single good frame, latency and one-cycle valid
    valid_cycles = 0;
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b1);
    hold(1'b1, 20);
    wait_drain(200);
    check_eq("t1_latency", rise_cyc - fall_cyc, 32'd611);
    check_eq("t1_valid_cycles", valid_cycles, 32'd1);
    check_eq("t1_data_out", {24'b0, stream_if.data_out}, 32'hA5);

    // 2: short low glitch is rejected
    t0 = cyc;
    hold(1'b0, 20);
    check_eq("t2_busy_rise", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t2_busy_fall", {31'b0, busy}, 32'd0);
    check_eq("t2_fall_by_36", {31'b0, (cyc - t0) <= 36}, 32'd1);
    hold(1'b1, 100);
    check_eq("t2_no_valid", valid_cycles, 32'd1);
    check_eq("t2_no_ferr", ferr_seen, 32'd0);

    // 3: bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b1, 100);
    check_eq("t3_ferr_pulse", ferr_seen, 32'd1);
    check_eq("t3_no_valid", valid_cycles, 32'd1);
    check_eq("t3_data_kept", {24'b0, stream_if.data_out}, 32'hA5);

    // 4: overrun with consumer stalled
    stream_if.data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    hold(1'b1, 40);
    check_eq("t4_overrun", ovr_seen, 32'd1);
    check_eq("t4_data_out", {24'b0, stream_if.data_out}, 32'h22);
    check_eq("t4_valid_held", {31'b0, stream_if.data_valid}, 32'd1);
    exp_q.push_back(8'h22);
    stream_if.data_ready = 1'b1;
    @(negedge clk);
    stream_if.data_ready = 1'b0;
    @(negedge clk);
    check_eq("t4_valid_clear", {31'b0, stream_if.data_valid}, 32'd0);
    check_eq("t4_popped", exp_q.size(), 32'd0);
    stream_if.data_ready = 1'b1;

    // 5: back-to-back frames
    v_before = valid_cycles;
    w_before = words_seen;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1);
    hold(1'b1, 40);
    wait_drain(200);
    check_eq("t5_words", words_seen - w_before, 32'd3);
    check_eq("t5_valid_cycles", valid_cycles - v_before, 32'd3);
    check_eq("t5_no_ferr", ferr_seen, 32'd1);
    check_eq("t5_no_ovr", ovr_seen, 32'd1);

    // 6: reset in the middle of data bit 4
    c3 = 8'hC3;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(c3[i], BIT_CLK);
    hold(c3[4], BIT_CLK / 2);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_data_out", {24'b0, stream_if.data_out}, 32'd0);
    check_eq("t6_rst_valid", {31'b0, stream_if.data_valid}, 32'd0);
    check_eq("t6_rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hold(1'b1, 50);
    send_frame(8'h96, 1'b1, 1'b1);
    hold(1'b1, 40);
    wait_drain(200);
    check_eq("t6_data_out", {24'b0, stream_if.data_out}, 32'h96);
    check_eq("t6_no_ferr", ferr_seen, 32'd1);
    check_eq("total_words", words_seen, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
